// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, opcode and select codes for the RV32I multicycle control FSM
//
// Purpose: single source of encodings used by mc_control_fsm and branch_cond.
// Ports: none (package).

package mc_ctrl_pkg;

    // State codes are visible on state_dbg, so their values are fixed.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXE_R     = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_EXE_I     = 4'd9,
        S_JAL       = 4'd10,
        S_LUI       = 4'd11,
        S_JALR_ADDR = 4'd12,
        S_AUIPC     = 4'd13,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RD2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_DATA   = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/mc_control_fsm_branch_cond.sv
// rtl/mc_control_fsm_branch_cond.sv - combinational branch-taken decode from funct3 and ALU flags
//
// Ports:
//   funct3     in  3  branch funct3 from the IR
//   zero       in  1  ALU result == 0
//   lt         in  1  signed rd1 < rd2
//   ltu        in  1  unsigned rd1 < rd2
//   taken      out 1  branch condition holds
//   bad_funct3 out 1  funct3 is not a defined branch (010/011)

module branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       bad_funct3
);

    always_comb begin
        taken      = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: bad_funct3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RV32I main control FSM with memory handshake, timeout and traps
//
// Parameters:
//   MEM_HANDSHAKE  1 = memory states wait for mem_ready, 0 = mem_ready treated as 1
//   TIMEOUT_W      wait counter width (>=2); timeout after 2^TIMEOUT_W-1 stalled cycles
// Ports:
//   clk, rst (async, active-low)
//   op, funct3                      instruction fields from the IR
//   zero, lt, ltu                   ALU compare flags
//   mem_ready                       memory completes the current access
//   sel_alu_src_a/b, alu_op         ALU operand and operation selects
//   sel_result, sel_mem_addr        result and address muxes
//   mem_req, we_mem, we_ir,
//   pc_write, we_rf                 datapath enables
//   instr_done                      pulse in the final state of an instruction
//   illegal, bus_err                sticky trap causes
//   state_dbg                       current state code

module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic [1:0] sel_alu_src_a,
    output logic [1:0] sel_alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] sel_result,
    output logic       sel_mem_addr,
    output logic       mem_req,
    output logic       we_mem,
    output logic       we_ir,
    output logic       pc_write,
    output logic       we_rf,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state_dbg
);

    localparam logic [TIMEOUT_W-1:0] WAIT_MAX = '1;

    state_t               state;
    state_t               next_state;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 rdy;
    logic                 mem_access;
    logic                 timeout;
    logic                 taken;
    logic                 bad_funct3;
    logic                 set_illegal;
    logic                 set_bus_err;

    branch_cond u_branch_cond (
        .funct3     (funct3),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .taken      (taken),
        .bad_funct3 (bad_funct3)
    );

    assign rdy        = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
    assign mem_access = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // A ready arriving on the terminal-count cycle wins over the timeout.
    assign timeout    = (MEM_HANDSHAKE != 0) && mem_access && !mem_ready && (wait_cnt == WAIT_MAX);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (rdy || (next_state != state)) begin
                wait_cnt <= '0;
            end else if (mem_access && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // First trap cause wins; the other flag is locked out.
            if (set_illegal && !bus_err) begin
                illegal <= 1'b1;
            end
            if (set_bus_err && !illegal) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state    = state;
        sel_alu_src_a = SRC_A_PC;
        sel_alu_src_b = SRC_B_RD2;
        alu_op        = ALU_OP_ADD;
        sel_result    = RESULT_ALUOUT;
        sel_mem_addr  = 1'b0;
        mem_req       = 1'b0;
        we_mem        = 1'b0;
        we_ir         = 1'b0;
        pc_write      = 1'b0;
        we_rf         = 1'b0;
        instr_done    = 1'b0;
        set_illegal   = 1'b0;
        set_bus_err   = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req       = 1'b1;
                sel_alu_src_b = SRC_B_FOUR;
                sel_result    = RESULT_ALU;
                we_ir         = rdy;
                pc_write      = rdy;
                if (rdy) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the PC-relative target into ALUOut.
                sel_alu_src_a = SRC_A_OLD_PC;
                sel_alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                    OP_R:              next_state = S_EXE_R;
                    OP_I:              next_state = S_EXE_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR_ADDR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default: begin
                        next_state  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                sel_alu_src_a = SRC_A_RD1;
                sel_alu_src_b = SRC_B_IMM;
                next_state    = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                sel_mem_addr = 1'b1;
                if (rdy) begin
                    next_state = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                sel_result = RESULT_DATA;
                we_rf      = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                sel_mem_addr = 1'b1;
                we_mem       = 1'b1;
                if (rdy) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXE_R: begin
                sel_alu_src_a = SRC_A_RD1;
                alu_op        = ALU_OP_FUNCT;
                next_state    = S_ALU_WB;
            end
            S_EXE_I: begin
                sel_alu_src_a = SRC_A_RD1;
                sel_alu_src_b = SRC_B_IMM;
                alu_op        = ALU_OP_FUNCT;
                next_state    = S_ALU_WB;
            end
            S_ALU_WB: begin
                we_rf      = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                sel_alu_src_a = SRC_A_RD1;
                alu_op        = ALU_OP_SUB;
                if (bad_funct3) begin
                    next_state  = S_TRAP;
                    set_illegal = 1'b1;
                end else begin
                    pc_write   = taken;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_JAL: begin
                // PC <- ALUOut (target) while the ALU forms the link value.
                sel_alu_src_a = SRC_A_OLD_PC;
                sel_alu_src_b = SRC_B_FOUR;
                pc_write      = 1'b1;
                next_state    = S_ALU_WB;
            end
            S_JALR_ADDR: begin
                sel_alu_src_a = SRC_A_RD1;
                sel_alu_src_b = SRC_B_IMM;
                next_state    = S_JAL;
            end
            S_LUI: begin
                sel_alu_src_a = SRC_A_ZERO;
                sel_alu_src_b = SRC_B_IMM;
                next_state    = S_ALU_WB;
            end
            S_AUIPC: begin
                sel_alu_src_a = SRC_A_OLD_PC;
                sel_alu_src_b = SRC_B_IMM;
                next_state    = S_ALU_WB;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_TRAP;
            end
        endcase

        if (timeout) begin
            next_state  = S_TRAP;
            set_bus_err = 1'b1;
            mem_req     = 1'b0;
            we_mem      = 1'b0;
            we_ir       = 1'b0;
            pc_write    = 1'b0;
            we_rf       = 1'b0;
            instr_done  = 1'b0;
        end

        // No side effects may leak out while reset is held.
        if (!rst) begin
            mem_req    = 1'b0;
            we_mem     = 1'b0;
            we_ir      = 1'b0;
            pc_write   = 1'b0;
            we_rf      = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm across three parameter sets

module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;

    logic [1:0] o_a [3];
    logic [1:0] o_b [3];
    logic [1:0] o_alu [3];
    logic [1:0] o_res [3];
    logic       o_maddr [3];
    logic       o_req [3];
    logic       o_wem [3];
    logic       o_wir [3];
    logic       o_pcw [3];
    logic       o_wrf [3];
    logic       o_done [3];
    logic       o_ill [3];
    logic       o_berr [3];
    logic [3:0] o_st [3];

    always #5 clk = ~clk;

    // 0: handshake, TIMEOUT_W=8   1: handshake, TIMEOUT_W=2   2: no handshake
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control_fsm #(
            .MEM_HANDSHAKE ((g == 2) ? 0 : 1),
            .TIMEOUT_W     ((g == 1) ? 2 : 8)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .op            (op),
            .funct3        (funct3),
            .zero          (zero),
            .lt            (lt),
            .ltu           (ltu),
            .mem_ready     (mem_ready),
            .sel_alu_src_a (o_a[g]),
            .sel_alu_src_b (o_b[g]),
            .alu_op        (o_alu[g]),
            .sel_result    (o_res[g]),
            .sel_mem_addr  (o_maddr[g]),
            .mem_req       (o_req[g]),
            .we_mem        (o_wem[g]),
            .we_ir         (o_wir[g]),
            .pc_write      (o_pcw[g]),
            .we_rf         (o_wrf[g]),
            .instr_done    (o_done[g]),
            .illegal       (o_ill[g]),
            .bus_err       (o_berr[g]),
            .state_dbg     (o_st[g])
        );
    end

    // en = {mem_req, we_mem, we_ir, pc_write, we_rf, instr_done, illegal, bus_err}
    typedef struct {
        logic       rdy;
        logic [3:0] st;
        logic [7:0] en;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    inst = 0;
    string tname = "";

    // {src_a, src_b, alu_op, sel_result, sel_mem_addr} expected in each state
    function automatic logic [8:0] spec_sels(input logic [3:0] st);
        case (st)
            4'd0:    return {2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
            4'd1:    return {2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd2:    return {2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd3:    return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
            4'd4:    return {2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
            4'd5:    return {2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
            4'd6:    return {2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
            4'd8:    return {2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
            4'd9:    return {2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
            4'd10:   return {2'b01, 2'b10, 2'b00, 2'b00, 1'b0};
            4'd11:   return {2'b11, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd12:   return {2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
            4'd13:   return {2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
            default: return 9'd0;
        endcase
    endfunction

    task automatic push(input logic r, input logic [3:0] s, input logic [7:0] e);
        exp_t x;
        x.rdy = r;
        x.st  = s;
        x.en  = e;
        sb.push_back(x);
    endtask

    // Called at posedge+1; drains the scoreboard one cycle per entry.
    task automatic play();
        exp_t        x;
        logic [20:0] obs;
        logic [20:0] req;
        int          cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            mem_ready = x.rdy;
            @(negedge clk);
            obs = {o_st[inst], o_a[inst], o_b[inst], o_alu[inst], o_res[inst], o_maddr[inst],
                   o_req[inst], o_wem[inst], o_wir[inst], o_pcw[inst], o_wrf[inst],
                   o_done[inst], o_ill[inst], o_berr[inst]};
            req = {x.st, spec_sels(x.st), x.en};
            checks++;
            if (obs !== req) begin
                errors++;
                $display("FAIL %s cycle %0d: got st=%0d sel=%b en=%b, expected st=%0d sel=%b en=%b",
                         tname, cyc, obs[20:17], obs[16:8], obs[7:0], req[20:17], req[16:8], req[7:0]);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Asserts reset asynchronously and checks its effect before any clock edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({o_st[inst], o_ill[inst], o_berr[inst], o_req[inst], o_wem[inst], o_wir[inst],
             o_pcw[inst], o_wrf[inst]} !== 11'd0) begin
            errors++;
            $display("FAIL %s async_reset: got st=%0d ill=%b berr=%b req=%b wem=%b wir=%b pcw=%b wrf=%b, expected all 0",
                     tname, o_st[inst], o_ill[inst], o_berr[inst], o_req[inst], o_wem[inst],
                     o_wir[inst], o_pcw[inst], o_wrf[inst]);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tname = "reset";
        inst  = 0;
        do_reset();
    endtask

    task automatic test_lw();
        tname = "lw_wait";
        inst  = 0;
        op    = 7'b0000011;
        funct3 = 3'b010;
        do_reset();
        repeat (3) push(1'b0, 4'd0, 8'b1000_0000);
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd2, 8'b0000_0000);
        repeat (2) push(1'b0, 4'd3, 8'b1000_0000);
        push(1'b1, 4'd3, 8'b1000_0000);
        push(1'b0, 4'd4, 8'b0000_1100);
        push(1'b0, 4'd0, 8'b1000_0000);
        play();
    endtask

    task automatic test_branch();
        inst = 0;
        op   = 7'b1100011;
        do_reset();
        tname = "bne_taken";
        funct3 = 3'b001; zero = 1'b0; ltu = 1'b0;
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd8, 8'b0001_0100);
        play();
        tname = "bne_not_taken";
        zero = 1'b1;
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd8, 8'b0000_0100);
        play();
        tname = "bgeu_ltu";
        funct3 = 3'b111; zero = 1'b0; ltu = 1'b1;
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd8, 8'b0000_0100);
        play();
        tname = "blt_taken";
        funct3 = 3'b100; lt = 1'b1;
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd8, 8'b0001_0100);
        play();
        tname = "branch_bad_funct3";
        funct3 = 3'b010; zero = 1'b1;
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd8, 8'b0000_0000);
        push(1'b1, 4'd15, 8'b0000_0010);
        push(1'b0, 4'd15, 8'b0000_0010);
        play();
        lt = 1'b0; ltu = 1'b0; zero = 1'b0;
    endtask

    task automatic test_jalr();
        tname = "jalr";
        inst  = 0;
        op    = 7'b1100111;
        do_reset();
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd12, 8'b0000_0000);
        push(1'b0, 4'd10, 8'b0001_0000);
        push(1'b0, 4'd7, 8'b0000_1100);
        push(1'b0, 4'd0, 8'b1000_0000);
        play();
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [4];
        logic [3:0] sts [4];
        inst = 0;
        ops[0] = 7'b0110011; sts[0] = 4'd6;
        ops[1] = 7'b0010011; sts[1] = 4'd9;
        ops[2] = 7'b0110111; sts[2] = 4'd11;
        ops[3] = 7'b0010111; sts[3] = 4'd13;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tname = $sformatf("alu_op_%0d", i);
            op = ops[i];
            push(1'b1, 4'd0, 8'b1011_0000);
            push(1'b0, 4'd1, 8'b0000_0000);
            push(1'b0, sts[i], 8'b0000_0000);
            push(1'b0, 4'd7, 8'b0000_1100);
            play();
        end
    endtask

    task automatic test_timeout();
        inst = 1;
        op   = 7'b0100011;
        tname = "sw_timeout";
        do_reset();
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd2, 8'b0000_0000);
        repeat (3) push(1'b0, 4'd5, 8'b1100_0000);
        push(1'b0, 4'd5, 8'b0000_0000);
        push(1'b1, 4'd15, 8'b0000_0001);
        push(1'b0, 4'd15, 8'b0000_0001);
        play();
        tname = "sw_ready_at_terminal";
        do_reset();
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd2, 8'b0000_0000);
        repeat (3) push(1'b0, 4'd5, 8'b1100_0000);
        push(1'b1, 4'd5, 8'b1100_0100);
        push(1'b0, 4'd0, 8'b1000_0000);
        play();
    endtask

    task automatic test_illegal();
        tname = "illegal_op";
        inst  = 0;
        op    = 7'b1111111;
        do_reset();
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        repeat (20) push(1'($urandom_range(0, 1)), 4'd15, 8'b0000_0010);
        play();
        tname = "illegal_async_clear";
        do_reset();
    endtask

    task automatic test_no_handshake();
        tname = "sw_no_handshake";
        inst  = 2;
        op    = 7'b0100011;
        do_reset();
        push(1'b0, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd2, 8'b0000_0000);
        push(1'b0, 4'd5, 8'b1100_0100);
        push(1'b0, 4'd0, 8'b1011_0000);
        play();
    endtask

    task automatic test_reset_mid();
        tname = "reset_mid_load";
        inst  = 0;
        op    = 7'b0000011;
        do_reset();
        push(1'b1, 4'd0, 8'b1011_0000);
        push(1'b0, 4'd1, 8'b0000_0000);
        push(1'b0, 4'd2, 8'b0000_0000);
        play();
        do_reset();
        push(1'b0, 4'd0, 8'b1000_0000);
        push(1'b1, 4'd0, 8'b1011_0000);
        play();
    endtask

    initial begin
        #1;
        test_reset();
        test_lw();
        test_branch();
        test_jalr();
        test_alu_ops();
        test_timeout();
        test_illegal();
        test_no_handshake();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
